// File: rtl/fpu_result_wb.sv
// FPU result writeback FIFO: buffers {result, exception, tag}; optional NaN canonicalisation under FPU_WB_NAN_CANON_EN.
// Latency: 1 cycle push to o_valid, no bypass. Backpressure: holds head while i_ready=0; full pushes are dropped and flagged.
// Sticky exception accumulation; o_almost_full is a registered stall request for issue.
module fpu_result_wb #(
  parameter int WIDTH     = 32,
  parameter int TAG_W     = 5,
  parameter int DEPTH     = 4,
  parameter int AFULL_LVL = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  input  logic [WIDTH-1:0]           i_result,
  input  logic [4:0]                 i_exeption,
  input  logic [TAG_W-1:0]           i_tag,
  output logic                       o_valid,
  input  logic                       i_ready,
  output logic [WIDTH-1:0]           o_result,
  output logic [4:0]                 o_exeption,
  output logic [TAG_W-1:0]           o_tag,
  output logic [4:0]                 o_sticky_exeption,
  input  logic                       i_clear_sticky,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_almost_full,
  output logic                       o_drop
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] res_mem [DEPTH];
  logic [4:0]       exc_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem [DEPTH];

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic [4:0]       sticky, sticky_nxt;
  logic             afull, drop;
  logic             pop, push_ok;
  logic [WIDTH-1:0] wr_res;

  assign pop     = (count != '0) && i_ready;
  assign push_ok = i_valid && ((count < CW'(DEPTH)) || pop);

  always_comb begin
    wr_res = i_result;
`ifdef FPU_WB_NAN_CANON_EN
    // Any NaN, signalling or quiet, leaves as the positive quiet canonical NaN.
    if (i_result[30:23] == 8'hff && i_result[22:0] != 23'd0)
      wr_res = WIDTH'(32'h7fc00000);
`endif
  end

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  // A clear collides with an accepted push by keeping only that push's flags.
  always_comb begin
    sticky_nxt = i_clear_sticky ? 5'd0 : sticky;
    if (push_ok)
      sticky_nxt = sticky_nxt | i_exeption;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        res_mem[i] <= '0;
        exc_mem[i] <= '0;
        tag_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sticky <= '0;
      afull  <= 1'b0;
      drop   <= 1'b0;
    end else begin
      if (push_ok) begin
        res_mem[wr_ptr] <= wr_res;
        exc_mem[wr_ptr] <= i_exeption;
        tag_mem[wr_ptr] <= i_tag;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count  <= count_nxt;
      sticky <= sticky_nxt;
      afull  <= (count_nxt >= CW'(AFULL_LVL));
      if (i_valid && !push_ok)
        drop <= 1'b1;
    end
  end

  assign o_valid           = (count != '0);
  assign o_result          = res_mem[rd_ptr];
  assign o_exeption        = exc_mem[rd_ptr];
  assign o_tag             = tag_mem[rd_ptr];
  assign o_count           = count;
  assign o_almost_full     = afull;
  assign o_drop            = drop;
  assign o_sticky_exeption = sticky;

endmodule
